// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// The loader's states, the frame's word-count width and the bytes per instruction word.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int CNT_W      = 16;
    localparam int WORD_BYTES = 4;

    // States in which the loader still consumes bytes from the stream.
    function automatic logic is_loading(input state_t s);
        return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// slave is the loader's view; master is the stream source / memory side.
interface instr_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wd
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wd
    );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words.
// Emits a one-cycle word_valid once the fourth byte of a word has been shifted in.
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word
);

    // The shift register doubles as the write-data register: it holds the full word
    // during the write pulse and only changes again when the next byte is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx   <= 2'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                word       <= {word[23:0], byte_data};
                byte_idx   <= byte_idx + 2'd1;
                word_valid <= (byte_idx == 2'(WORD_BYTES - 1));
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot-time program loader: parses a framed byte stream, writes words to instruction
// memory at consecutive addresses, then releases the core or latches an error.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic             master_clk,
    input  logic             rst_n,
    instr_loader_if.slave    bus,
    output logic             cpu_run,
    output logic             load_done,
    output logic             load_error
);

    localparam logic [CNT_W:0]    CAPACITY = (CNT_W + 1)'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic              armed_q;
    logic [7:0]        cnt_hi_q;
    logic [CNT_W-1:0]  words_left_q;
    logic [7:0]        xor_q;
    logic [ADDR_W-1:0] addr_q;

    logic              accept;
    logic              data_accept;
    logic [CNT_W-1:0]  hdr_count;
    logic              too_big;
    logic [1:0]        byte_idx;
    logic              last_byte;
    logic              word_valid;
    logic [31:0]       packed_word;

    assign accept      = bus.in_valid && bus.in_ready;
    assign data_accept = accept && (state_q == DATA);
    assign hdr_count   = {cnt_hi_q, bus.in_data};
    assign too_big     = {1'b0, hdr_count} > CAPACITY;
    assign last_byte   = (byte_idx == 2'(WORD_BYTES - 1));

    byte_packer u_packer (
        .clk        (master_clk),
        .rst_n      (rst_n),
        .byte_valid (data_accept),
        .byte_data  (bus.in_data),
        .byte_idx   (byte_idx),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    assign bus.imem_we   = word_valid;
    assign bus.imem_wd   = packed_word;
    assign bus.imem_addr = addr_q;

    // armed_q keeps in_ready low until the first edge that samples rst_n high.
    always_ff @(posedge master_clk) begin
        if (!rst_n) begin
            state_q      <= HDR_HI;
            armed_q      <= 1'b0;
            cnt_hi_q     <= 8'd0;
            words_left_q <= '0;
            xor_q        <= 8'd0;
            addr_q       <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (accept && (state_q != CHECK)) begin
                xor_q <= xor_q ^ bus.in_data;
            end
            if (accept && (state_q == HDR_HI)) begin
                cnt_hi_q <= bus.in_data;
            end
            if (accept && (state_q == HDR_LO)) begin
                words_left_q <= hdr_count;
            end else if (data_accept && last_byte) begin
                words_left_q <= words_left_q - CNT_W'(1);
            end
            if (word_valid && (addr_q != ADDR_MAX)) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = armed_q && is_loading(state_q);
        cpu_run      = (state_q == DONE);
        load_done    = (state_q == DONE);
        load_error   = (state_q == ERROR);
        case (state_q)
            HDR_HI: begin
                if (accept) state_d = HDR_LO;
            end
            HDR_LO: begin
                if (accept) begin
                    if (too_big)                state_d = ERROR;
                    else if (hdr_count == '0)   state_d = CHECK;
                    else                        state_d = DATA;
                end
            end
            DATA: begin
                if (data_accept && last_byte && (words_left_q == CNT_W'(1))) state_d = CHECK;
            end
            CHECK: begin
                if (accept) state_d = (bus.in_data == xor_q) ? DONE : ERROR;
            end
            default: state_d = state_q;
        endcase
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: frames are driven byte by byte while a negedge
// monitor checks every instruction-memory write against a queue of expected writes.
module tb_instr_loader;

    logic master_clk = 1'b0;
    logic rst_n      = 1'b0;
    logic cpu_run;
    logic load_done;
    logic load_error;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] words_q[$];

    instr_loader_if #(.ADDR_W(8)) bus ();

    instr_loader #(.ADDR_W(8)) dut (
        .master_clk (master_clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 master_clk = ~master_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every write pulse must match the oldest expected write.
    always @(negedge master_clk) begin
        if (bus.imem_we === 1'b1) begin
            checkOutput("cpu_run_during_write", {31'd0, cpu_run}, 32'd0);
            if (exp_addr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         bus.imem_addr, bus.imem_wd);
            end else begin
                checkOutput("imem_addr", {24'd0, bus.imem_addr}, {24'd0, exp_addr_q.pop_front()});
                checkOutput("imem_wd", bus.imem_wd, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendByte(input logic [7:0] b, input int max_gap);
        int gap;
        int t;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge master_clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
        @(negedge master_clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge master_clk);
            t++;
        end
        if (bus.in_ready !== 1'b1) begin
            checkOutput("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        end
        @(posedge master_clk);
    endtask

    task automatic doReset();
        @(negedge master_clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge master_clk);
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
        checkOutput("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
        checkOutput("rst_imem_wd", bus.imem_wd, 32'd0);
        checkOutput("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
        checkOutput("rst_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("rst_load_error", {31'd0, load_error}, 32'd0);
        rst_n = 1'b1;
        @(negedge master_clk);
        checkOutput("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Sends header, the words in words_q (when has_body) and the checksum XOR csum_flip.
    task automatic applyStimulus(input logic [15:0] n, input logic [7:0] csum_flip,
                                 input int max_gap, input bit has_body);
        logic [7:0] x;
        logic [7:0] bv;
        logic [31:0] w;
        x = n[15:8] ^ n[7:0];
        sendByte(n[15:8], 0);
        sendByte(n[7:0], 0);
        if (has_body) begin
            for (int i = 0; i < words_q.size(); i++) begin
                w = words_q[i];
                exp_addr_q.push_back(i[7:0]);
                exp_data_q.push_back(w);
                for (int b = 3; b >= 0; b--) begin
                    bv = w[8*b +: 8];
                    x  = x ^ bv;
                    sendByte(bv, max_gap);
                end
            end
            sendByte(x ^ csum_flip, max_gap);
        end
    endtask

    task automatic checkStatus(input string tag, input bit ok);
        @(negedge master_clk);
        bus.in_valid = 1'b0;
        checkOutput({tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, ok});
        checkOutput({tag, "_load_done"}, {31'd0, load_done}, {31'd0, ok});
        checkOutput({tag, "_load_error"}, {31'd0, load_error}, {31'd0, !ok});
        checkOutput({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        checkOutput({tag, "_pending_writes"}, exp_addr_q.size(), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        doReset();
        words_q = '{32'h20080005, 32'hAC080000};
        applyStimulus(16'd2, 8'h00, 0, 1'b1);
        checkStatus("good_frame", 1'b1);

        doReset();
        applyStimulus(16'd2, 8'h01, 0, 1'b1);
        checkStatus("bad_csum", 1'b0);

        doReset();
        applyStimulus(16'h0101, 8'h00, 0, 1'b0);
        checkStatus("over_capacity", 1'b0);

        doReset();
        words_q.delete();
        for (int i = 0; i < 256; i++) begin
            words_q.push_back({i[7:0], 8'h5A, ~i[7:0], 8'hC3});
        end
        applyStimulus(16'h0100, 8'h00, 0, 1'b1);
        checkStatus("full_capacity", 1'b1);

        doReset();
        words_q.delete();
        applyStimulus(16'd0, 8'h00, 0, 1'b1);
        checkStatus("empty_frame", 1'b1);

        doReset();
        words_q = '{32'h20080005, 32'hAC080000};
        applyStimulus(16'd2, 8'h00, 3, 1'b1);
        checkStatus("gapped_frame", 1'b1);

        doReset();
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        exp_addr_q.push_back(8'h00);
        exp_data_q.push_back(32'h20080005);
        sendByte(8'h20, 0);
        sendByte(8'h08, 0);
        sendByte(8'h00, 0);
        sendByte(8'h05, 0);
        sendByte(8'hAC, 0);
        doReset();
        checkOutput("mid_data_pending_writes", exp_addr_q.size(), 32'd0);
        applyStimulus(16'd2, 8'h00, 0, 1'b1);
        checkStatus("reload_after_reset", 1'b1);

        repeat (3) @(negedge master_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
